// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM encoding, default widths and the
// peripheral register map offsets that benches and completers reuse.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int APB_ADDR_WIDTH_DEF = 8;
    localparam int APB_DATA_WIDTH_DEF = 32;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_DATA     = 8'h08;
    localparam logic [7:0] REG_ADDR     = 8'h0C;
    localparam logic [7:0] REG_IRQ_EN   = 8'h10;
    localparam logic [7:0] REG_IRQ_STAT = 8'h14;

    // Bits needed to hold 0..limit; at least one so a disabled timer still elaborates.
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-cycle counter; expired flags the wait cycle that
// brings the count up to a non-zero limit.
module apb_wait_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH:0]   count_inc;

    assign count_inc = {1'b0, count_reg} + {{WIDTH{1'b0}}, 1'b1};

    // Combinational so the abort happens on the same edge the count reaches the limit.
    assign expired = (limit != '0) && enable && (count_inc >= {1'b0, limit});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != '1)) begin
            count_reg <= count_inc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts a command, runs SETUP/ACCESS on the
// bus with an optional wait timeout, and holds the response until consumed.
module apb_master
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int TW = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    apb_state_t state_reg, state_next;

    logic                      write_reg;
    logic [APB_ADDR_WIDTH-1:0] addr_reg;
    logic [APB_DATA_WIDTH-1:0] wdata_reg;
    logic [APB_DATA_WIDTH-1:0] rdata_reg;
    logic                      err_reg;
    logic                      timeout_reg;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // Counter restarts while in SETUP so every ACCESS phase starts from zero.
    assign timer_clear  = (state_reg == ST_SETUP);
    assign timer_enable = (state_reg == ST_ACCESS) && !pready;

    apb_wait_timer #(
        .WIDTH (TW)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (LIMIT),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                psel       = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || timer_expired) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && cmd_valid) begin
                write_reg <= cmd_write;
                addr_reg  <= cmd_addr;
                wdata_reg <= cmd_wdata;
            end
            if ((state_reg == ST_ACCESS) && pready) begin
                // Read data is only meaningful for a clean read.
                rdata_reg   <= (write_reg || pslverr) ? '0 : prdata;
                err_reg     <= pslverr;
                timeout_reg <= 1'b0;
            end else if ((state_reg == ST_ACCESS) && timer_expired) begin
                rdata_reg   <= '0;
                err_reg     <= 1'b1;
                timeout_reg <= 1'b1;
            end
        end
    end

    assign pwrite      = write_reg;
    assign paddr       = addr_reg;
    assign pwdata      = wdata_reg;
    assign rsp_rdata   = rdata_reg;
    assign rsp_err     = err_reg;
    assign rsp_timeout = timeout_reg;

endmodule
